// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
// Shares one 4-digit seven-segment driver between four binary sources.
// Round-robin arbitration picks a winner, a 14-step double-dabble engine
// converts it to packed BCD, and the winner stays on the display for
// DWELL_CYCLES clocks before re-arbitration.
// Optional build macro SEG_BLANK_IDLE_EN: when defined, falling back to IDLE
// with no requesters blanks the display (bcd_num = 16'hFFFF) with one
// bcd_valid pulse. When undefined, IDLE keeps the last value on the display.
module seg_display_scheduler #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BIN_W        = 14
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [3:0]         req,
    input  logic [4*BIN_W-1:0] bin_flat,
    input  logic               lock,
    output logic [15:0]        bcd_num,
    output logic [15:0]        displayed_number,
    output logic [1:0]         src_sel,
    output logic               bcd_valid,
    output logic               busy,
    output logic               ovf
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_CONVERT = 3'd2,
        S_LOAD    = 3'd3,
        S_DWELL   = 3'd4
    } state_t;

    // First set request bit after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    function automatic logic [29:0] dd_step(input logic [15:0] bcd, input logic [13:0] bin);
        logic [15:0] adj;
        logic [29:0] cat;
        for (int k = 0; k < 4; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end else begin
                adj[4*k +: 4] = bcd[4*k +: 4];
            end
        end
        cat     = {adj, bin};
        dd_step = {cat[28:0], 1'b0};
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_dwell_cnt;
    logic [3:0]         r_conv_cnt;
    logic [1:0]         r_last_sel;
    logic [1:0]         r_win;
    logic [BIN_W-1:0]   r_val;
    logic               r_ovf_pend;
    logic [BIN_W-1:0]   r_bin;
    logic [15:0]        r_bcd;
    logic [15:0]        r_bcd_num;
    logic [15:0]        r_disp_num;
    logic [1:0]         r_src_sel;
    logic               r_bcd_valid;
    logic               r_busy;
    logic               r_ovf;

    logic [1:0]         w_win;
    logic [BIN_W-1:0]   w_win_raw;
    logic               w_win_sat;
    logic [BIN_W-1:0]   w_win_val;
    logic               w_dwell_done;
    logic [29:0]        w_dd;
    logic               w_load_evt;
    logic               w_blank_evt;
    logic               w_busy_nxt;

    assign w_win        = rr_pick(req, r_last_sel);
    assign w_win_raw    = bin_flat[w_win*BIN_W +: BIN_W];
    assign w_win_sat    = (w_win_raw > 14'd9999);
    assign w_win_val    = w_win_sat ? 14'd9999 : w_win_raw;
    assign w_dwell_done = !lock && (r_dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
    assign w_dd         = dd_step(r_bcd, r_bin);

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req != 4'b0000) w_state_nxt = S_ARB;
                else                w_state_nxt = S_IDLE;
            end
            S_ARB: begin
                if (req == 4'b0000) w_state_nxt = S_IDLE;
                else                w_state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                if (r_conv_cnt == 4'd13) w_state_nxt = S_LOAD;
                else                     w_state_nxt = S_CONVERT;
            end
            S_LOAD: begin
                w_state_nxt = S_DWELL;
            end
            S_DWELL: begin
                // A dropped request and an expiring count collapse into one ARB.
                if (!req[r_src_sel] || w_dwell_done) w_state_nxt = S_ARB;
                else                                 w_state_nxt = S_DWELL;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output-event decode: result load, optional blanking, busy level.
    always_comb begin
        w_load_evt  = 1'b0;
        w_blank_evt = 1'b0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_load_evt = 1'b1;
            end
            S_ARB: begin
`ifdef SEG_BLANK_IDLE_EN
                w_blank_evt = (req == 4'b0000);
`else
                w_blank_evt = 1'b0;
`endif
            end
            default: begin
                w_load_evt  = 1'b0;
                w_blank_evt = 1'b0;
            end
        endcase
        case (w_state_nxt)
            S_ARB, S_CONVERT, S_LOAD: w_busy_nxt = 1'b1;
            default:                  w_busy_nxt = 1'b0;
        endcase
    end

    // Dwell counter: counts DWELL cycles unless locked, cleared on leaving DWELL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dwell_cnt <= '0;
        end else if (r_state == S_DWELL && w_state_nxt == S_DWELL) begin
            if (!lock) r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
            else       r_dwell_cnt <= r_dwell_cnt;
        end else begin
            r_dwell_cnt <= '0;
        end
    end

    // Winner capture and the double-dabble engine; bin_flat is sampled only in ARB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win      <= 2'd0;
            r_val      <= '0;
            r_ovf_pend <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= 16'd0;
            r_conv_cnt <= 4'd0;
            r_last_sel <= 2'd3;
        end else if (r_state == S_ARB && req != 4'b0000) begin
            r_win      <= w_win;
            r_val      <= w_win_val;
            r_ovf_pend <= w_win_sat;
            r_bin      <= w_win_val;
            r_bcd      <= 16'd0;
            r_conv_cnt <= 4'd0;
        end else if (r_state == S_CONVERT) begin
            r_bcd      <= w_dd[29:14];
            r_bin      <= w_dd[13:0];
            r_conv_cnt <= r_conv_cnt + 4'd1;
        end else if (r_state == S_LOAD) begin
            r_last_sel <= r_win;
        end else begin
            r_last_sel <= r_last_sel;
        end
    end

    // Registered display outputs; they change only on a load or a blank event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bcd_num   <= 16'd0;
            r_disp_num  <= 16'd0;
            r_src_sel   <= 2'd0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_bcd_valid <= w_load_evt | w_blank_evt;
            r_busy      <= w_busy_nxt;
            if (w_load_evt) begin
                r_bcd_num  <= r_bcd;
                r_disp_num <= {2'b00, r_val};
                r_src_sel  <= r_win;
                r_ovf      <= r_ovf_pend;
            end else if (w_blank_evt) begin
                r_bcd_num  <= 16'hFFFF;
                r_disp_num <= 16'd0;
                r_ovf      <= 1'b0;
            end else begin
                r_bcd_num  <= r_bcd_num;
            end
        end
    end

    assign bcd_num          = r_bcd_num;
    assign displayed_number = r_disp_num;
    assign src_sel          = r_src_sel;
    assign bcd_valid        = r_bcd_valid;
    assign busy             = r_busy;
    assign ovf              = r_ovf;

endmodule
